// File: rtl/blockram_port_requester_pkg.sv
// Shared definitions for the block RAM port requester: request-type encoding
// and response-queue pointer sizing.
package blockram_port_requester_pkg;

  localparam int unsigned BYTE_LEN_IN_BITS = 8;

  // An all-zero byte write mask marks a read request.
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  function automatic int unsigned queue_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/blockram_port_requester_resp_fifo.sv
// Synchronous response FIFO carrying {tag, hit, entry}; exposes occupancy so the
// requester can size its read credits. A push while full is dropped unless a pop frees a slot.
module blockram_resp_fifo
  import blockram_port_requester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 69,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                              clk_in,
  input  logic                              reset_n_in,
  input  logic                              push_in,
  input  logic [DATA_WIDTH-1:0]             push_data_in,
  input  logic                              pop_in,
  output logic [DATA_WIDTH-1:0]             head_data_out,
  output logic                              empty_out,
  output logic [queue_ptr_width(DEPTH):0]   occupancy_out
);

  localparam int unsigned PTR_W = queue_ptr_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop_in & (count != '0);
    do_push = push_in & (~full | do_pop);
  end

  // Storage is cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data_out = mem[rd_ptr];
  assign empty_out     = (count == '0);
  assign occupancy_out = count;

endmodule

// File: rtl/blockram_port_requester.sv
// Initiator front end for one block RAM port: valid/ready requests to RAM accesses,
// credit-gated reads with an in-order response queue. Optional: BLOCKRAM_PORT_REQUESTER_PERF_CNT_EN.
module blockram_port_requester
  import blockram_port_requester_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_SET                    = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int unsigned WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int unsigned TAG_WIDTH_IN_BITS          = 4,
  parameter int unsigned RESP_QUEUE_DEPTH           = 4
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic                                  req_valid_in,
  output logic                                  req_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      req_addr_in,
  input  logic [WRITE_MASK_LEN-1:0]             req_write_en_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] req_write_entry_in,
  input  logic [TAG_WIDTH_IN_BITS-1:0]          req_tag_in,
  output logic                                  ram_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]             ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]      ram_access_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_write_entry_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_read_entry_in,
  input  logic                                  ram_read_valid_in,
  output logic                                  resp_valid_out,
  input  logic                                  resp_ready_in,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] resp_entry_out,
  output logic                                  resp_hit_out,
  output logic [TAG_WIDTH_IN_BITS-1:0]          resp_tag_out
`ifdef BLOCKRAM_PORT_REQUESTER_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_read_cnt_out,
  output logic [31:0]                           perf_write_cnt_out,
  output logic [31:0]                           perf_stall_cnt_out
`endif
);

  localparam int unsigned PTR_W  = queue_ptr_width(RESP_QUEUE_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned RESP_W = TAG_WIDTH_IN_BITS + 1 + SINGLE_ENTRY_WIDTH_IN_BITS;

  req_type_e                    req_type;
  logic                         read_credit_ok;
  logic                         accept;
  logic                         in_flight;
  logic [TAG_WIDTH_IN_BITS-1:0] in_flight_tag;
  logic [CNT_W-1:0]             occupancy;
  logic                         fifo_empty;
  logic [RESP_W-1:0]            fifo_head;
  logic                         resp_pop;

  // In-flight read holds a credit too, so the queue can never be pushed past full.
  always_comb begin
    req_type       = (|req_write_en_in) ? REQ_WRITE : REQ_READ;
    read_credit_ok = ({{PTR_W{1'b0}}, in_flight} + occupancy) < CNT_W'(RESP_QUEUE_DEPTH);
    req_ready_out  = (req_type == REQ_READ) ? read_credit_ok : 1'b1;
    accept         = req_valid_in & req_ready_out;
  end

  always_comb begin
    ram_access_en_out       = accept;
    ram_write_en_out        = accept ? req_write_en_in : '0;
    ram_access_set_addr_out = req_addr_in;
    ram_write_entry_out     = req_write_entry_in;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      in_flight     <= 1'b0;
      in_flight_tag <= '0;
    end else begin
      in_flight <= accept & (req_type == REQ_READ);
      if (accept && (req_type == REQ_READ)) in_flight_tag <= req_tag_in;
    end
  end

  assign resp_pop = resp_valid_out & resp_ready_in;

  blockram_resp_fifo #(
    .DATA_WIDTH (RESP_W),
    .DEPTH      (RESP_QUEUE_DEPTH)
  ) u_resp_fifo (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .push_in       (in_flight),
    .push_data_in  ({in_flight_tag, ram_read_valid_in, ram_read_entry_in}),
    .pop_in        (resp_pop),
    .head_data_out (fifo_head),
    .empty_out     (fifo_empty),
    .occupancy_out (occupancy)
  );

  assign resp_valid_out = ~fifo_empty;
  assign {resp_tag_out, resp_hit_out, resp_entry_out} = fifo_head;

`ifdef BLOCKRAM_PORT_REQUESTER_PERF_CNT_EN
  logic read_evt;
  logic write_evt;
  logic stall_evt;

  always_comb begin
    read_evt  = accept & (req_type == REQ_READ);
    write_evt = accept & (req_type == REQ_WRITE);
    stall_evt = req_valid_in & ~req_ready_out;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      perf_read_cnt_out  <= '0;
      perf_write_cnt_out <= '0;
      perf_stall_cnt_out <= '0;
    end else begin
      if (read_evt && (perf_read_cnt_out != '1))   perf_read_cnt_out  <= perf_read_cnt_out + 1'b1;
      if (write_evt && (perf_write_cnt_out != '1)) perf_write_cnt_out <= perf_write_cnt_out + 1'b1;
      if (stall_evt && (perf_stall_cnt_out != '1)) perf_stall_cnt_out <= perf_stall_cnt_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_blockram_port_requester.sv
// Bench for blockram_port_requester: RAM port model plus a transaction-level
// reference (shadow memory and queue of outstanding reads with due times).
module tb_blockram_port_requester;

  localparam int unsigned EW    = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned MW    = 8;
  localparam int unsigned TW    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          reset_n_in;
  logic          req_valid_in;
  logic          req_ready_out;
  logic [AW-1:0] req_addr_in;
  logic [MW-1:0] req_write_en_in;
  logic [EW-1:0] req_write_entry_in;
  logic [TW-1:0] req_tag_in;
  logic          ram_access_en_out;
  logic [MW-1:0] ram_write_en_out;
  logic [AW-1:0] ram_access_set_addr_out;
  logic [EW-1:0] ram_write_entry_out;
  logic [EW-1:0] ram_read_entry_in = '0;
  logic          ram_read_valid_in = 1'b0;
  logic          resp_valid_out;
  logic          resp_ready_in;
  logic [EW-1:0] resp_entry_out;
  logic          resp_hit_out;
  logic [TW-1:0] resp_tag_out;
`ifdef BLOCKRAM_PORT_REQUESTER_PERF_CNT_EN
  logic [31:0]   perf_read_cnt_out;
  logic [31:0]   perf_write_cnt_out;
  logic [31:0]   perf_stall_cnt_out;
`endif

  always #5 clk_in = ~clk_in;

  blockram_port_requester #(
    .SINGLE_ENTRY_WIDTH_IN_BITS (EW),
    .NUM_SET                    (64),
    .TAG_WIDTH_IN_BITS          (TW),
    .RESP_QUEUE_DEPTH           (DEPTH)
  ) dut (
    .clk_in                  (clk_in),
    .reset_n_in              (reset_n_in),
    .req_valid_in            (req_valid_in),
    .req_ready_out           (req_ready_out),
    .req_addr_in             (req_addr_in),
    .req_write_en_in         (req_write_en_in),
    .req_write_entry_in      (req_write_entry_in),
    .req_tag_in              (req_tag_in),
    .ram_access_en_out       (ram_access_en_out),
    .ram_write_en_out        (ram_write_en_out),
    .ram_access_set_addr_out (ram_access_set_addr_out),
    .ram_write_entry_out     (ram_write_entry_out),
    .ram_read_entry_in       (ram_read_entry_in),
    .ram_read_valid_in       (ram_read_valid_in),
    .resp_valid_out          (resp_valid_out),
    .resp_ready_in           (resp_ready_in),
    .resp_entry_out          (resp_entry_out),
    .resp_hit_out            (resp_hit_out),
    .resp_tag_out            (resp_tag_out)
`ifdef BLOCKRAM_PORT_REQUESTER_PERF_CNT_EN
    ,
    .perf_read_cnt_out       (perf_read_cnt_out),
    .perf_write_cnt_out      (perf_write_cnt_out),
    .perf_stall_cnt_out      (perf_stall_cnt_out)
`endif
  );

  function automatic logic [EW-1:0] merge(input logic [EW-1:0] old, input logic [EW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [EW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Block RAM port: byte-masked write, registered read with "ever written" valid.
  logic [EW-1:0] ram_mem [64] = '{default: '0};
  logic          ram_wr  [64] = '{default: 1'b0};

  always @(posedge clk_in) begin
    if (ram_access_en_out) begin
      if (ram_write_en_out != '0) begin
        ram_mem[ram_access_set_addr_out] <= merge(ram_mem[ram_access_set_addr_out],
                                                  ram_write_entry_out, ram_write_en_out);
        ram_wr[ram_access_set_addr_out]  <= 1'b1;
      end else begin
        ram_read_entry_in <= ram_mem[ram_access_set_addr_out];
        ram_read_valid_in <= ram_wr[ram_access_set_addr_out];
      end
    end
  end

  typedef struct {
    logic [EW-1:0] entry;
    logic          hit;
    logic [TW-1:0] tag;
    int unsigned   due;
  } exp_t;

  exp_t          q[$];
  logic [EW-1:0] ref_mem [64];
  logic          ref_wr  [64];
  int unsigned   edges;
  int unsigned   n_checks;
  int unsigned   n_errors;

  task automatic check_eq(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check mid-cycle against the reference, then advance it.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [MW-1:0] m,
                      input logic [EW-1:0] d, input logic [TW-1:0] t, input logic rr,
                      output logic acc);
    logic exp_ready;
    logic exp_valid;
    logic is_wr;
    exp_t e;
    req_valid_in       = v;
    req_addr_in        = a;
    req_write_en_in    = m;
    req_write_entry_in = d;
    req_tag_in         = t;
    resp_ready_in      = rr;
    #3;
    is_wr     = (m != '0);
    exp_ready = is_wr || (q.size() < DEPTH);
    acc       = v && exp_ready;
    check_eq("req_ready", req_ready_out, exp_ready);
    check_eq("ram_access_en", ram_access_en_out, acc);
    if (acc) begin
      check_eq("ram_write_en", ram_write_en_out, m);
      check_eq("ram_addr", ram_access_set_addr_out, a);
      if (is_wr) check_eq("ram_wdata", ram_write_entry_out, d);
    end
    exp_valid = 1'b0;
    if (q.size() > 0) exp_valid = (q[0].due <= edges);
    check_eq("resp_valid", resp_valid_out, exp_valid);
    if (exp_valid) begin
      check_eq("resp_entry", resp_entry_out, q[0].entry);
      check_eq("resp_hit", resp_hit_out, q[0].hit);
      check_eq("resp_tag", resp_tag_out, q[0].tag);
    end
    @(posedge clk_in);
    if (exp_valid && rr) void'(q.pop_front());
    if (acc) begin
      if (is_wr) begin
        ref_mem[a] = merge(ref_mem[a], d, m);
        ref_wr[a]  = 1'b1;
      end else begin
        e.entry = ref_mem[a];
        e.hit   = ref_wr[a];
        e.tag   = t;
        e.due   = edges + 2;
        q.push_back(e);
      end
    end
    edges++;
    #1;
  endtask

  task automatic idle(input logic rr, input int unsigned n);
    logic acc;
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, rr, acc);
  endtask

  // Keep presenting a read until accepted; an expired budget is a failed comparison.
  task automatic read_until(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic rr);
    logic acc;
    int unsigned n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 12) begin
      step(1'b1, a, '0, '0, t, rr, acc);
      n++;
    end
    check_eq("read_accept_budget", {63'd0, acc}, 64'd1);
  endtask

  initial begin
    logic          acc;
    logic [MW-1:0] m;
    n_checks = 0;
    n_errors = 0;
    edges    = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = '0;
      ref_wr[i]  = 1'b0;
    end
    reset_n_in         = 1'b0;
    req_valid_in       = 1'b0;
    req_addr_in        = '0;
    req_write_en_in    = '0;
    req_write_entry_in = '0;
    req_tag_in         = '0;
    resp_ready_in      = 1'b0;
    #2;
    check_eq("rst_resp_valid", resp_valid_out, 0);
    check_eq("rst_resp_entry", resp_entry_out, 0);
    check_eq("rst_resp_hit", resp_hit_out, 0);
    check_eq("rst_resp_tag", resp_tag_out, 0);
    check_eq("rst_read_ready", req_ready_out, 1);
    check_eq("rst_access_en", ram_access_en_out, 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;

    // Full write then read: fixed two-cycle response latency.
    step(1'b1, 6'd5, 8'hFF, 64'h1122334455667788, 4'd0, 1'b0, acc);
    step(1'b1, 6'd5, 8'h00, '0, 4'd3, 1'b0, acc);
    check_eq("t1_not_early", resp_valid_out, 0);
    idle(1'b0, 1);
    check_eq("t1_valid", resp_valid_out, 1);
    check_eq("t1_entry", resp_entry_out, 64'h1122334455667788);
    check_eq("t1_hit", resp_hit_out, 1);
    check_eq("t1_tag", resp_tag_out, 3);
    idle(1'b1, 1);

    // Never-written address.
    step(1'b1, 6'd9, 8'h00, '0, 4'd1, 1'b1, acc);
    idle(1'b1, 1);
    check_eq("t2_valid", resp_valid_out, 1);
    check_eq("t2_hit", resp_hit_out, 0);
    idle(1'b1, 1);

    // Partial write keeps the upper bytes.
    step(1'b1, 6'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 4'd0, 1'b0, acc);
    step(1'b1, 6'd5, 8'h00, '0, 4'd2, 1'b0, acc);
    idle(1'b0, 1);
    check_eq("t3_entry", resp_entry_out, 64'h11223344AAAAAAAA);
    idle(1'b1, 2);

    // Queue full: reads stall, writes still pass, then in-order drain.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 8'h00, '0, TW'(i), 1'b0, acc);
    req_valid_in    = 1'b1;
    req_write_en_in = '0;
    req_addr_in     = 6'd4;
    #1;
    check_eq("t4_full_ready", req_ready_out, 0);
    step(1'b1, 6'd7, 8'hFF, 64'hDEADBEEF0BADF00D, 4'd0, 1'b0, acc);
    check_eq("t4_tag0_head", resp_tag_out, 0);
    read_until(6'd4, 4'd4, 1'b1);
    read_until(6'd5, 4'd5, 1'b1);
    idle(1'b1, 8);

    // Back-to-back reads give back-to-back responses.
    for (int i = 1; i <= 3; i++) step(1'b1, AW'(i), 8'h00, '0, TW'(i + 8), 1'b1, acc);
    idle(1'b1, 5);

    // Reset with two queued responses and one read in flight.
    for (int i = 0; i < 3; i++) step(1'b1, AW'(10 + i), 8'h00, '0, TW'(7 + i), 1'b0, acc);
    req_valid_in = 1'b0;
    reset_n_in   = 1'b0;
    #1;
    check_eq("rst_mid_valid", resp_valid_out, 0);
    q.delete();
    @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    idle(1'b0, 2);
    for (int i = 0; i < 5; i++) step(1'b1, AW'(20 + i), 8'h00, '0, TW'(i), 1'b0, acc);
    idle(1'b1, 8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      m = ($urandom_range(0, 1) == 0) ? 8'h00 : MW'($urandom_range(1, 255));
      step(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 15)), m,
           {$urandom(), $urandom()}, TW'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 6), acc);
    end
    idle(1'b1, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
